min_queue: RTL and testbench

MIN_QUEUE -- requirements
Module: min_queue

---
 rtl/min_queue_if.sv | 27 ++
 rtl/min_queue.sv | 177 +++++++++++++++++
 tb/tb_min_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/min_queue_if.sv
// Handshake bundle of the min_queue: an insert channel (producer -> queue)
// and a presentation channel (queue -> consumer) that carries the current
// minimum key and the slot it lives in.
interface min_queue_if #(
  parameter int WIDTH  = 3,
  parameter int LENGTH = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;
  logic [WIDTH-1:0]  out_index;

  // Queue side: accepts inserts, presents the minimum.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/min_queue.sv
// Small priority queue: 2**WIDTH key slots, a recursive argmin tree picks the
// smallest occupied key, and a registered output stage presents it until the
// consumer pops it.

// Recursive argmin over 2**WIDTH keys of KW bits. Each level splits the key
// vector in half; on equal keys the lower half wins, so ties resolve to the
// lower slot index.
module argmin #(
  parameter int WIDTH = 3,
  parameter int KW    = 11
) (
  input  logic [(2**WIDTH)*KW-1:0] keys_i,
  output logic [KW-1:0]            min_key_o,
  output logic [WIDTH-1:0]         min_idx_o
);
  if (WIDTH == 1) begin : g_leaf
    logic [KW-1:0] key_lo;
    logic [KW-1:0] key_hi;
    logic          hi_wins;

    assign key_lo    = keys_i[KW-1:0];
    assign key_hi    = keys_i[2*KW-1:KW];
    assign hi_wins   = key_hi < key_lo;
    assign min_key_o = hi_wins ? key_hi : key_lo;
    assign min_idx_o = hi_wins;
  end else begin : g_node
    localparam int HALF = (2**(WIDTH-1))*KW;

    logic [KW-1:0]    key_lo;
    logic [KW-1:0]    key_hi;
    logic [WIDTH-2:0] idx_lo;
    logic [WIDTH-2:0] idx_hi;
    logic             hi_wins;

    argmin #(.WIDTH(WIDTH-1), .KW(KW)) u_lo (
      .keys_i    (keys_i[HALF-1:0]),
      .min_key_o (key_lo),
      .min_idx_o (idx_lo)
    );

    argmin #(.WIDTH(WIDTH-1), .KW(KW)) u_hi (
      .keys_i    (keys_i[2*HALF-1:HALF]),
      .min_key_o (key_hi),
      .min_idx_o (idx_hi)
    );

    assign hi_wins   = key_hi < key_lo;
    assign min_key_o = hi_wins ? key_hi : key_lo;
    assign min_idx_o = hi_wins ? {1'b1, idx_hi} : {1'b0, idx_lo};
  end
endmodule

module min_queue #(
  parameter int WIDTH  = 3,
  parameter int LENGTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  min_queue_if.slave       q,
  input  logic             clear,
  output logic [WIDTH:0]   count,
  output logic             full,
  output logic             empty
);
  localparam int             SLOTS   = 2**WIDTH;
  localparam int             KW      = LENGTH + 1;
  localparam logic [WIDTH:0] SLOTS_C = (WIDTH+1)'(SLOTS);
  localparam logic [WIDTH:0] ONE_C   = (WIDTH+1)'(1);

  logic [SLOTS-1:0]  valid_q,     valid_d;
  logic [LENGTH-1:0] key_q [SLOTS];
  logic [LENGTH-1:0] key_d [SLOTS];
  logic              out_valid_q, out_valid_d;
  logic [LENGTH-1:0] out_data_q,  out_data_d;
  logic [WIDTH-1:0]  out_index_q, out_index_d;
  logic [WIDTH:0]    count_q,     count_d;

  logic [SLOTS*KW-1:0] sel_keys;
  logic [KW-1:0]       min_key;
  logic [WIDTH-1:0]    min_idx;
  logic [WIDTH-1:0]    free_idx;
  logic                insert;
  logic                pop;

  assign full   = (count_q == SLOTS_C);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign insert = q.in_valid && !full;
  assign pop    = out_valid_q && q.out_ready;

  assign q.in_ready  = !full;
  assign q.out_valid = out_valid_q;
  assign q.out_data  = out_data_q;
  assign q.out_index = out_index_q;

  // Selection keys: the inverted valid bit on top makes every empty slot
  // compare larger than any occupied one, even an all-ones key.
  always_comb begin
    sel_keys = '0;
    for (int i = 0; i < SLOTS; i++) begin
      sel_keys[i*KW +: KW] = {~valid_q[i], key_q[i]};
    end
  end

  argmin #(.WIDTH(WIDTH), .KW(KW)) u_argmin (
    .keys_i    (sel_keys),
    .min_key_o (min_key),
    .min_idx_o (min_idx)
  );

  // Lowest-index free slot; scanning downward leaves the lowest one last.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = WIDTH'(i);
    end
  end

  // Next state: insert into the free slot, pop the presented slot, and
  // reload the output stage from the argmin only when it is empty.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    valid_d     = valid_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    count_d     = count_q;

    if (insert) begin
      valid_d[free_idx] = 1'b1;
      key_d[free_idx]   = q.in_data;
    end

    // A pop targets an occupied slot, so it never collides with the insert.
    if (pop) begin
      valid_d[out_index_q] = 1'b0;
      out_valid_d          = 1'b0;
    end else if (!out_valid_q && |valid_q) begin
      out_valid_d = 1'b1;
      out_data_d  = min_key[LENGTH-1:0];
      out_index_d = min_idx;
    end

    if (insert && !pop) begin
      count_d = count_q + ONE_C;
    end else if (pop && !insert) begin
      count_d = count_q - ONE_C;
    end
  end

  // State registers; reset and clear both flush everything on the edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    if (rst || clear) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      count_q     <= '0;
      // NOTE: the key array is deliberately reset as well; keys read as zero
      // after a flush instead of holding stale data.
      for (int i = 0; i < SLOTS; i++) begin
        key_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: tb/tb_min_queue.sv
// Directed bench for min_queue (WIDTH=3, LENGTH=10). Inputs change 1 time
// unit after each rising edge; outputs are checked at that same point, away
// from the next active edge.
module tb_min_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  min_queue_if #(.WIDTH(3), .LENGTH(10)) bus ();

  min_queue #(.WIDTH(3), .LENGTH(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .q     (bus),
    .clear (clear),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output stage and occupancy in one go.
  task automatic chk_out(input string tag, input logic ov, input int od, input int oi, input int cnt);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk({tag, ".out_data"},  32'(bus.out_data),  od);
      chk({tag, ".out_index"}, 32'(bus.out_index), oi);
    end
    chk({tag, ".count"}, 32'(count), cnt);
  endtask

  task automatic cyc(input logic v, input logic [9:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clear         = 1'b0;
    rst           = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;

    // Reset state.
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.out_data",  32'(bus.out_data),  0);
    chk("rst.out_index", 32'(bus.out_index), 0);
    chk("rst.count",     32'(count),         0);
    chk("rst.empty",     32'(empty),         1);
    chk("rst.full",      32'(full),          0);
    chk("rst.in_ready",  32'(bus.in_ready),  1);

    // Ordered pops: 5,3,9 plus a trailing 100 that stays presented in slot 3.
    cyc(1, 5, 0);    chk_out("ins5",   0, 0, 0, 1);
    cyc(1, 3, 0);    chk_out("ins3",   1, 5, 0, 2);
    cyc(1, 9, 0);    chk_out("ins9",   1, 5, 0, 3);
    cyc(1, 100, 0);  chk_out("ins100", 1, 5, 0, 4);
    cyc(0, 0, 1);    chk_out("pop5",   0, 0, 0, 3);
    cyc(0, 0, 1);    chk_out("ld3",    1, 3, 1, 3);
    cyc(0, 0, 1);    chk_out("pop3",   0, 0, 0, 2);
    cyc(0, 0, 1);    chk_out("ld9",    1, 9, 2, 2);
    cyc(0, 0, 1);    chk_out("pop9",   0, 0, 0, 1);
    cyc(0, 0, 0);    chk_out("ld100",  1, 100, 3, 1);

    // Tie and all-ones key: slots 0..2 are free while 100 holds the stage.
    cyc(1, 1023, 0); chk_out("ins1023", 1, 100, 3, 2);
    cyc(1, 7, 0);    chk_out("ins7a",   1, 100, 3, 3);
    cyc(1, 7, 0);    chk_out("ins7b",   1, 100, 3, 4);
    cyc(0, 0, 1);    chk_out("pop100",  0, 0, 0, 3);
    cyc(0, 0, 1);    chk_out("ld7a",    1, 7, 1, 3);
    cyc(0, 0, 1);    chk_out("pop7a",   0, 0, 0, 2);
    cyc(0, 0, 1);    chk_out("ld7b",    1, 7, 2, 2);
    cyc(0, 0, 1);    chk_out("pop7b",   0, 0, 0, 1);
    cyc(0, 0, 1);    chk_out("ld1023",  1, 1023, 0, 1);
    cyc(0, 0, 1);    chk_out("pop1023", 0, 0, 0, 0);
    chk("tie.empty", 32'(empty), 1);
    cyc(0, 0, 0);    chk_out("idle", 0, 0, 0, 0);

    // Full: keys 80,70,...,10 into slots 0..7.
    for (int i = 0; i < 8; i++) cyc(1, 10'(80 - 10*i), 0);
    chk_out("full8", 1, 80, 0, 8);
    chk("full8.full",     32'(full),         1);
    chk("full8.in_ready", 32'(bus.in_ready), 0);
    cyc(1, 0, 0);    chk_out("ins_when_full", 1, 80, 0, 8);

    // Pop with in_valid while full: insert waits for in_ready.
    cyc(1, 5, 1);    chk_out("pop_full", 0, 0, 0, 7);
    chk("pop_full.in_ready", 32'(bus.in_ready), 1);
    cyc(1, 5, 0);    chk_out("ins5_late", 1, 10, 7, 8);
    cyc(0, 0, 1);    chk_out("pop10",     0, 0, 0, 7);
    cyc(0, 0, 0);    chk_out("ld5_slot0", 1, 5, 0, 7);
    cyc(0, 0, 1);    chk_out("pop5b",     0, 0, 0, 6);
    cyc(0, 0, 0);    chk_out("ld20",      1, 20, 6, 6);
    cyc(0, 0, 1);    chk_out("pop20",     0, 0, 0, 5);
    cyc(0, 0, 0);    chk_out("ld30",      1, 30, 5, 5);

    // Reset mid-operation with 5 entries and the stage loaded.
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    chk("mrst.out_valid", 32'(bus.out_valid), 0);
    chk("mrst.out_data",  32'(bus.out_data),  0);
    chk("mrst.out_index", 32'(bus.out_index), 0);
    chk("mrst.count",     32'(count),         0);
    chk("mrst.empty",     32'(empty),         1);
    cyc(1, 42, 0);   chk_out("ins42", 0, 0, 0, 1);
    cyc(0, 0, 0);    chk_out("ld42",  1, 42, 0, 1);

    // Simultaneous pop and insert with 4 entries: new key goes to slot 4.
    cyc(1, 11, 0);   chk_out("ins11", 1, 42, 0, 2);
    cyc(1, 12, 0);   chk_out("ins12", 1, 42, 0, 3);
    cyc(1, 13, 0);   chk_out("ins13", 1, 42, 0, 4);
    cyc(1, 3, 1);    chk_out("pop_ins", 0, 0, 0, 4);
    cyc(0, 0, 0);    chk_out("ld3_slot4", 1, 3, 4, 4);
    cyc(0, 0, 1);    chk_out("pop3b", 0, 0, 0, 3);

    // Clear with 3 entries and a concurrent insert: everything flushed.
    clear = 1'b1;
    cyc(1, 1, 0);
    clear = 1'b0;
    chk_out("clear", 0, 0, 0, 0);
    chk("clear.empty",    32'(empty),        1);
    chk("clear.out_data", 32'(bus.out_data), 0);
    cyc(0, 0, 0);    chk_out("after_clear", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
